// File: rtl/counter6_pkg.sv
// Shared types and phase constants for the counter6 scheduler slice.
// The phase values mirror the external six-phase counter's contract.
package counter6_pkg;

    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] phase_t;

    localparam phase_t PH_IDLE    = 3'd0;
    localparam phase_t PH_LAST    = 3'd5;
    localparam phase_t PH_RESTART = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_RESTART,
        ST_DRAIN
    } state_e;

    // Owner-index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter6_sched_if.sv
// Requester and counter-side signals of the scheduler.
// master = scheduler, slave = requesters plus counter feedback.
interface counter6_sched_if
    import counter6_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] restart_req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  owner_id;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic             seq_start;
    logic             seq_changed;
    phase_t           seq_cnt;

    modport master (
        input  req, restart_req, seq_cnt,
        output grant, owner_id, done, busy, seq_start, seq_changed
    );

    modport slave (
        output req, restart_req, seq_cnt,
        input  grant, owner_id, done, busy, seq_start, seq_changed
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Zero latency; gnt_o is all zero when no request is set.
module rr_pick
    import counter6_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

    logic [ID_W:0] slot;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        slot  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (slot >= NREQ_W) slot = slot - NREQ_W;
            if (!found && req_i[slot[ID_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[slot[ID_W-1:0]]  = 1'b1;
                idx_o                  = slot[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/counter6_sched.sv
// Round-robin owner of a shared counter6: grant 1 cycle after req, one start per run, done on 5->0.
// Requesters are never preempted; a dropped req aborts and the run drains to phase 0 unreported.
module counter6_sched
    import counter6_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    counter6_sched_if.master bus
);
    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             changed;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             own_req, own_restart, cnt_live, cnt_bad;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign own_req     = bus.req[owner_q];
    assign own_restart = bus.restart_req[owner_q];
    assign cnt_live    = (bus.seq_cnt != PH_IDLE) && (bus.seq_cnt <= PH_LAST);
    assign cnt_bad     = (bus.seq_cnt > PH_LAST) && (bus.seq_cnt != PH_RESTART);
    assign next_ptr    = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
        busy_d   = busy_q;
        start_d  = 1'b0;
        changed  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req && bus.seq_cnt == PH_IDLE) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (cnt_bad || !own_req) begin
                    grant_d = '0;
                    state_d = ST_DRAIN;
                end else if (own_restart && cnt_live) begin
                    // Combinational so the counter jumps to 7 on the phase the owner asked,
                    // including phase 5 where a registered pulse would arrive after the wrap.
                    changed = 1'b1;
                    state_d = ST_RESTART;
                end else if (bus.seq_cnt == PH_LAST) begin
                    done_d   = grant_q;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end
            ST_RESTART: begin
                if (cnt_bad) begin
                    grant_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (bus.seq_cnt == PH_IDLE) begin
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner_id    = owner_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.seq_start   = start_q;
    assign bus.seq_changed = changed;
endmodule
